buf_seg_sequencer: RTL and testbench

// - Staged enable controller for a segmented output buffer: the 36x driver built as N_SEG parallel tristate slices.
// - Turns slices on/off one at a time, STEP_CYC clocks apart, to limit supply inrush and ground bounce.
// - Sits beside the buffer macro; its thermometer-coded SEG_EN drives the slice enables directly.

---
 rtl/buf_seg_sequencer_pkg.sv | 25 ++
 rtl/buf_seg_sequencer_if.sv | 15 +
 rtl/buf_seg_sequencer_timer.sv | 24 ++
 rtl/buf_seg_sequencer.sv | 85 ++++++++
 tb/tb_buf_seg_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/buf_seg_sequencer_pkg.sv
// Shared definitions for the segmented-buffer enable sequencer: defaults,
// FSM state encoding and the goal clamp helper.
package buf_seg_sequencer_pkg;

    localparam int N_SEG_DEF    = 6;
    localparam int STEP_CYC_DEF = 4;
    localparam int CNT_W_DEF    = 3;
    localparam int TMR_W_DEF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Requested slice count, clamped to the number of physical slices.
    function automatic int clamp_goal(input logic en, input int tgt, input int n_seg);
        if (!en) begin
            return 0;
        end
        return (tgt > n_seg) ? n_seg : tgt;
    endfunction

endpackage

// File: rtl/buf_seg_sequencer_if.sv
// Request/status bundle between the buffer controller and the sequencer.
interface buf_seg_sequencer_if #(
    parameter int N_SEG = 6,
    parameter int CNT_W = 3
);
    logic             en;
    logic [CNT_W-1:0] tgt;
    logic [N_SEG-1:0] seg_en;
    logic             rdy;
    logic             busy;
    logic [1:0]       state;

    modport master (output en, tgt, input seg_en, rdy, busy, state);
    modport slave  (input en, tgt, output seg_en, rdy, busy, state);
endinterface

// File: rtl/buf_seg_sequencer_timer.sv
// Reloadable down-counter that saturates at zero; paces slice changes.
module buf_seg_sequencer_timer #(
    parameter int STEP_CYC = 4,
    parameter int TMR_W    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_zero
);
    logic [TMR_W-1:0] r_tmr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (i_load) begin
            r_tmr <= TMR_W'(STEP_CYC - 1);
        end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

    assign o_zero = (r_tmr == '0);
endmodule

// File: rtl/buf_seg_sequencer.sv
// Staged slice-enable controller: walks the enabled slice count one step at
// a time toward the clamped goal, at least STEP_CYC clocks between changes.
module buf_seg_sequencer
    import buf_seg_sequencer_pkg::*;
#(
    parameter int N_SEG    = N_SEG_DEF,
    parameter int STEP_CYC = STEP_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TMR_W    = TMR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    buf_seg_sequencer_if.slave bus
);
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_goal;
    logic [N_SEG-1:0] r_seg_en;
    logic [N_SEG-1:0] w_therm;
    logic             r_rdy;
    logic             r_busy;
    logic             w_zero;
    logic             w_step;
    state_t           r_state;
    state_t           w_state_next;

    assign w_goal = CNT_W'(clamp_goal(bus.en, int'(bus.tgt), N_SEG));
    assign w_step = w_zero && (r_count != w_goal);

    buf_seg_sequencer_timer #(
        .STEP_CYC (STEP_CYC),
        .TMR_W    (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_step),
        .o_zero (w_zero)
    );

    // Next count and state; state is judged on the post-step count so the
    // status outputs change on the same edge as the slice enables.
    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;
        if (w_step) begin
            w_count_next = (r_count < w_goal) ? r_count + 1'b1 : r_count - 1'b1;
        end
        if (w_count_next < w_goal) begin
            w_state_next = ST_UP;
        end else if (w_count_next > w_goal) begin
            w_state_next = ST_DOWN;
        end else if (w_goal == '0) begin
            w_state_next = ST_IDLE;
        end else begin
            w_state_next = ST_HOLD;
        end
    end

    generate
        for (genvar gi = 0; gi < N_SEG; gi++) begin : g_therm
            assign w_therm[gi] = (w_count_next > CNT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_seg_en <= '0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            r_count  <= w_count_next;
            r_seg_en <= w_therm;
            r_rdy    <= (w_state_next == ST_HOLD);
            r_busy   <= (w_state_next == ST_UP) || (w_state_next == ST_DOWN);
            r_state  <= w_state_next;
        end
    end

    assign bus.seg_en = r_seg_en;
    assign bus.rdy    = r_rdy;
    assign bus.busy   = r_busy;
    assign bus.state  = r_state;
endmodule

// File: tb/tb_buf_seg_sequencer.sv
// Self-checking bench: per-edge scoreboard against a behavioural model, a
// table of retarget vectors, and hand sequences for reversal and async reset.
module tb_buf_seg_sequencer;
    localparam int N_SEG    = 6;
    localparam int STEP_CYC = 4;
    localparam int CNT_W    = 3;
    localparam int TMR_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buf_seg_sequencer_if #(.N_SEG(N_SEG), .CNT_W(CNT_W)) bus ();

    buf_seg_sequencer #(
        .N_SEG    (N_SEG),
        .STEP_CYC (STEP_CYC),
        .CNT_W    (CNT_W),
        .TMR_W    (TMR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [5:0] seg;
        logic       rdy;
        logic       busy;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        logic       en;
        logic [2:0] tgt;
        int         ncyc;
        logic [5:0] seg;
        logic       rdy;
        logic       busy;
        logic [1:0] st;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_count = 0;
    int   m_tmr   = 0;
    int   edge_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Advance one clock: model predicts, scoreboard holds it, DUT is compared after the edge.
    task automatic tick();
        int   g;
        exp_t e;
        exp_t got;
        g = bus.en ? ((int'(bus.tgt) > N_SEG) ? N_SEG : int'(bus.tgt)) : 0;
        if (m_tmr == 0 && m_count != g) begin
            m_count = (m_count < g) ? m_count + 1 : m_count - 1;
            m_tmr   = STEP_CYC - 1;
        end else if (m_tmr > 0) begin
            m_tmr--;
        end
        e.seg  = 6'((1 << m_count) - 1);
        e.rdy  = (m_count == g) && (g != 0);
        e.busy = (m_count != g);
        e.st   = (m_count == g) ? ((g == 0) ? 2'd0 : 2'd3) : ((m_count < g) ? 2'd1 : 2'd2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        edge_no++;
        got = sb_q.pop_front();
        chk($sformatf("seg_en@%0d", edge_no), 32'(bus.seg_en), 32'(got.seg));
        chk($sformatf("rdy@%0d", edge_no), 32'(bus.rdy), 32'(got.rdy));
        chk($sformatf("busy@%0d", edge_no), 32'(bus.busy), 32'(got.busy));
        chk($sformatf("state@%0d", edge_no), 32'(bus.state), 32'(got.st));
    endtask

    // Assert reset between edges, check outputs clear with no edge, release before next edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_seg_en"}, 32'(bus.seg_en), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.rdy), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        m_count = 0;
        m_tmr   = 0;
        sb_q.delete();
        @(negedge clk);
        rst     = 1'b0;
        edge_no = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // en, tgt, cycles, final seg_en, rdy, busy, state
        vecs[0] = '{1'b0, 3'd6, 24, 6'b000000, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 3'd7, 24, 6'b111111, 1'b1, 1'b0, 2'd3};
        vecs[2] = '{1'b1, 3'd2, 16, 6'b000011, 1'b1, 1'b0, 2'd3};
        vecs[3] = '{1'b1, 3'd0,  8, 6'b000000, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{1'b1, 3'd3, 12, 6'b000111, 1'b1, 1'b0, 2'd3};
        vecs[5] = '{1'b1, 3'd1,  8, 6'b000001, 1'b1, 1'b0, 2'd3};

        bus.en  = 1'b0;
        bus.tgt = '0;
        #12;
        chk("reset_seg_en", 32'(bus.seg_en), 32'd0);
        chk("reset_rdy", 32'(bus.rdy), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp up with explicit edge milestones.
        bus.en  = 1'b1;
        bus.tgt = 3'd6;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 1)  chk("ramp_first_slice", 32'(bus.seg_en), 32'h01);
            if (i == 4)  chk("ramp_hold_gap", 32'(bus.seg_en), 32'h01);
            if (i == 5)  chk("ramp_second_slice", 32'(bus.seg_en), 32'h03);
            if (i == 20) chk("ramp_busy_20", 32'(bus.busy), 32'd1);
            if (i == 21) chk("ramp_rdy_21", 32'(bus.rdy), 32'd1);
        end
        $display("[TB] ramp up: seg_en=%b rdy=%0b busy=%0b", bus.seg_en, bus.rdy, bus.busy);

        for (int v = 0; v < 6; v++) begin
            bus.en  = vecs[v].en;
            bus.tgt = vecs[v].tgt;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                tick();
            end
            chk($sformatf("vec%0d_seg_en", v), 32'(bus.seg_en), 32'(vecs[v].seg));
            chk($sformatf("vec%0d_rdy", v), 32'(bus.rdy), 32'(vecs[v].rdy));
            chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(vecs[v].busy));
            chk($sformatf("vec%0d_state", v), 32'(bus.state), 32'(vecs[v].st));
            $display("[TB] vec %0d en=%0b tgt=%0d -> seg_en=%b rdy=%0b busy=%0b",
                     v, vecs[v].en, vecs[v].tgt, bus.seg_en, bus.rdy, bus.busy);
        end

        // Reversal one edge after reaching three slices.
        async_reset("rev_reset");
        bus.en  = 1'b1;
        bus.tgt = 3'd6;
        for (int i = 0; i < 9; i++) tick();
        chk("rev_at3", 32'(bus.seg_en), 32'h07);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rev_wait", 32'(bus.seg_en), 32'h07);
        end
        tick();
        chk("rev_step", 32'(bus.seg_en), 32'h03);
        chk("rev_state", 32'(bus.state), 32'd2);
        $display("[TB] reversal: seg_en=%b state=%0d", bus.seg_en, bus.state);

        // Async reset mid-ramp, then first slice on the first edge after release.
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        #2;
        async_reset("mid_reset");
        tick();
        chk("post_reset_first", 32'(bus.seg_en), 32'h01);
        $display("[TB] async reset: seg_en=%b after first edge", bus.seg_en);

        // Fast EN toggling: model scoreboard enforces step spacing.
        for (int i = 0; i < 16; i++) begin
            bus.en = ~bus.en;
            tick();
        end
        $display("[TB] en toggle: seg_en=%b", bus.seg_en);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
